// File: rtl/spi_slave_framed.sv
// Framed SPI slave: deserialises {cmd[1:0], payload} frames from MOSI, checks the
// rd-addr/rd-data sequence and serialises RAM read data back on MISO.
module spi_slave_framed #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              busy,
  output logic              cmd_err,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TO_W    = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX      = 3'd1,
    S_WAIT_TX = 3'd2,
    S_TX      = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic               rd_pend_q;
  logic [FRAME_W-1:0] rx_shift_q;
  logic [FRAME_W-1:0] rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q;
  logic [FRAME_W-1:0] rx_data_q;
  logic               miso_q;
  logic               rx_valid_q;
  logic               busy_q;
  logic               cmd_err_q;
  logic               frame_err_q;
  logic [1:0]         cmd_d;
  logic               tx_first;
  logic [DATA_W-1:0]  tx_rest;
  logic               tx_head;
  logic [DATA_W-1:0]  tx_next;

  // Shift direction decides which end of the frame the first serial bit lands in.
  always_comb begin
    rx_shift_d = rx_shift_q;
    if (MSB_FIRST) begin
      rx_shift_d = {rx_shift_q[FRAME_W-2:0], MOSI};
    end else begin
      rx_shift_d = {MOSI, rx_shift_q[FRAME_W-1:1]};
    end
  end

  assign cmd_d = rx_shift_d[FRAME_W-1 -: 2];

  // Head-of-queue bit and remaining bits for both the load and the shift paths.
  assign tx_first = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
  assign tx_rest  = MSB_FIRST ? (tx_data << 1) : (tx_data >> 1);
  assign tx_head  = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
  assign tx_next  = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      if (state_q != S_IDLE && ss_n) begin
        // Deselect ends any transaction; only a finished readback or DONE is clean.
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        bit_cnt_q   <= '0;
        to_cnt_q    <= '0;
        frame_err_q <= (state_q == S_RX) || (state_q == S_WAIT_TX) ||
                       ((state_q == S_TX) && (bit_cnt_q != CNT_W'(DATA_W)));
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!ss_n) begin
              rx_shift_q <= rx_shift_d;
              bit_cnt_q  <= CNT_W'(1);
              busy_q     <= 1'b1;
              state_q    <= S_RX;
            end
          end
          S_RX: begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
              bit_cnt_q <= '0;
              if (cmd_d != 2'b11) begin
                rx_data_q  <= rx_shift_d;
                rx_valid_q <= 1'b1;
                state_q    <= S_DONE;
                if (cmd_d == 2'b10) begin
                  rd_pend_q <= 1'b1;
                end
              end else if (rd_pend_q) begin
                rx_data_q  <= rx_shift_d;
                rx_valid_q <= 1'b1;
                rd_pend_q  <= 1'b0;
                to_cnt_q   <= '0;
                state_q    <= S_WAIT_TX;
              end else begin
                cmd_err_q <= 1'b1;
                state_q   <= S_DONE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_WAIT_TX: begin
            if (tx_valid) begin
              miso_q     <= tx_first;
              tx_shift_q <= tx_rest;
              bit_cnt_q  <= CNT_W'(1);
              to_cnt_q   <= '0;
              state_q    <= S_TX;
            end else if (to_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
              frame_err_q <= 1'b1;
              to_cnt_q    <= '0;
              state_q     <= S_DONE;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          S_TX: begin
            // bit_cnt_q counts bits already on MISO; DATA_W means the last one has had its cycle.
            if (bit_cnt_q == CNT_W'(DATA_W)) begin
              bit_cnt_q <= '0;
              state_q   <= S_DONE;
            end else begin
              miso_q     <= tx_head;
              tx_shift_q <= tx_next;
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MISO      = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;

endmodule
